ex_mem_pipe: RTL and testbench

Parametrised EX→MEM pipeline stage register, the successor to the fixed-width free-running stage latch. It carries op, ALU result, store/branch address, write-enable and destination register from execute to memory. It adds a valid/ready handshake, an optional two-entry skid buffer for full-throughput backpressure, synchronous flush, and bubble masking so that MEM never sees a stale write-enable.

---
 rtl/ex_mem_pipe.sv | 119 +++++++++++
 tb/tb_ex_mem_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage: valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and bubble masking of the head-beat payload.
module ex_mem_pipe #(
    parameter int unsigned    OP_W    = 6,
    parameter int unsigned    DATA_W  = 32,
    parameter int unsigned    REG_W   = 5,
    parameter bit             SKID_EN = 1'b1,
    parameter logic [OP_W-1:0] NOP_OP = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_addr,
    input  logic              in_ife,
    input  logic [REG_W-1:0]  in_ri,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_addr,
    output logic              out_ife,
    output logic [REG_W-1:0]  out_ri,
    output logic [1:0]        occ
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] addr;
        logic              ife;
        logic [REG_W-1:0]  ri;
    } beat_t;

    logic  r_m_valid;
    logic  r_s_valid;
    beat_t r_m;
    beat_t r_s;

    logic  w_m_valid_nxt;
    logic  w_s_valid_nxt;
    beat_t w_m_nxt;
    beat_t w_s_nxt;
    beat_t w_in;
    logic  w_accept;
    logic  w_drain;

    assign w_in     = '{op: in_op, alu: in_alu, addr: in_addr, ife: in_ife, ri: in_ri};
    assign in_ready = SKID_EN ? !r_s_valid : (!r_m_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_m_valid && out_ready;

    // Next-state of the main and skid slots; flush overrides every other move.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_nxt       = r_m;
        w_s_nxt       = r_s;
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (SKID_EN) begin
            if (!r_m_valid || w_drain) begin
                if (r_s_valid) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_nxt       = r_s;
                    if (w_accept) begin
                        w_s_nxt = w_in;
                    end else begin
                        w_s_valid_nxt = 1'b0;
                    end
                end else if (w_accept) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_nxt       = w_in;
                end else begin
                    w_m_valid_nxt = 1'b0;
                end
            end else if (w_accept) begin
                w_s_valid_nxt = 1'b1;
                w_s_nxt       = w_in;
            end
        end else begin
            if (w_accept) begin
                w_m_valid_nxt = 1'b1;
                w_m_nxt       = w_in;
            end else if (w_drain) begin
                w_m_valid_nxt = 1'b0;
            end
        end
    end

    // Slot state and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_m       <= w_m_nxt;
            r_s       <= w_s_nxt;
        end
    end

    // Head beat with bubbles masked so MEM never sees a stale write-enable.
    assign out_valid = r_m_valid;
    assign out_op    = r_m_valid ? r_m.op   : NOP_OP;
    assign out_alu   = r_m_valid ? r_m.alu  : '0;
    assign out_addr  = r_m_valid ? r_m.addr : '0;
    assign out_ife   = r_m_valid ? r_m.ife  : 1'b0;
    assign out_ri    = r_m_valid ? r_m.ri   : '0;
    assign occ       = 2'(r_m_valid) + 2'(r_s_valid);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: skid and non-skid instances share stimulus and are
// each checked against a queue model of an ordered buffer.
module tb_ex_mem_pipe;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned PW     = OP_W + 2 * DATA_W + 1 + REG_W;
    localparam logic [OP_W-1:0] NOP1 = 6'h00;
    localparam logic [OP_W-1:0] NOP0 = 6'h3F;

    typedef logic [PW-1:0] pl_t;
    localparam pl_t BUB1 = pl_t'(NOP1) << (PW - OP_W);
    localparam pl_t BUB0 = pl_t'(NOP0) << (PW - OP_W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic [OP_W-1:0]   in_op = '0;
    logic [DATA_W-1:0] in_alu = '0;
    logic [DATA_W-1:0] in_addr = '0;
    logic              in_ife = 1'b0;
    logic [REG_W-1:0]  in_ri = '0;
    logic              flush = 1'b0;
    logic              out_ready = 1'b0;

    logic rdy1, ov1, ife1, rdy0, ov0, ife0;
    logic [OP_W-1:0]   op1, op0;
    logic [DATA_W-1:0] alu1, addr1, alu0, addr0;
    logic [REG_W-1:0]  ri1, ri0;
    logic [1:0]        occ1, occ0;

    ex_mem_pipe #(.OP_W(OP_W), .DATA_W(DATA_W), .REG_W(REG_W), .SKID_EN(1'b1), .NOP_OP(NOP1)) u_skid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_op(in_op), .in_alu(in_alu), .in_addr(in_addr), .in_ife(in_ife), .in_ri(in_ri),
        .flush(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_op(op1), .out_alu(alu1), .out_addr(addr1), .out_ife(ife1), .out_ri(ri1), .occ(occ1));

    ex_mem_pipe #(.OP_W(OP_W), .DATA_W(DATA_W), .REG_W(REG_W), .SKID_EN(1'b0), .NOP_OP(NOP0)) u_noskid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_op(in_op), .in_alu(in_alu), .in_addr(in_addr), .in_ife(in_ife), .in_ri(in_ri),
        .flush(flush), .out_valid(ov0), .out_ready(out_ready),
        .out_op(op0), .out_alu(alu0), .out_addr(addr0), .out_ife(ife0), .out_ri(ri0), .occ(occ0));

    pl_t q1[$];
    pl_t q0[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against model, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] addr, input logic ife, input logic [REG_W-1:0] ri,
                         input logic ordy, input logic fl);
        pl_t w;
        pl_t e1;
        pl_t e0;
        logic er1, er0, acc1, acc0, drn1, drn0;
        in_valid  = v;
        in_op     = op;
        in_alu    = alu;
        in_addr   = addr;
        in_ife    = ife;
        in_ri     = ri;
        out_ready = ordy;
        flush     = fl;
        w = {op, alu, addr, ife, ri};
        #2;
        er1 = (q1.size() < 2);
        er0 = (q0.size() == 0) || ordy;
        e1  = (q1.size() != 0) ? q1[0] : BUB1;
        e0  = (q0.size() != 0) ? q0[0] : BUB0;
        check("skid_in_ready", 128'(rdy1), 128'(er1));
        check("skid_out_valid", 128'(ov1), 128'(q1.size() != 0));
        check("skid_occ", 128'(occ1), 128'(q1.size()));
        check("skid_beat", 128'({op1, alu1, addr1, ife1, ri1}), 128'(e1));
        check("noskid_in_ready", 128'(rdy0), 128'(er0));
        check("noskid_out_valid", 128'(ov0), 128'(q0.size() != 0));
        check("noskid_occ", 128'(occ0), 128'(q0.size()));
        check("noskid_beat", 128'({op0, alu0, addr0, ife0, ri0}), 128'(e0));
        acc1 = v && er1;
        acc0 = v && er0;
        drn1 = (q1.size() != 0) && ordy;
        drn0 = (q0.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (drn1) void'(q1.pop_front());
            if (acc1) q1.push_back(w);
            if (drn0) void'(q0.pop_front());
            if (acc0) q0.push_back(w);
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, OP_W'($urandom), $urandom, $urandom, 1'b1, REG_W'($urandom), ordy, 1'b0);
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: 8 beats back to back.
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 6'h01, DATA_W'(32'h10 + i), $urandom, 1'b1, REG_W'(i + 1), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A, then B while stalled, then C held off until release.
        cycle(1'b1, 6'h02, 32'hA, 32'h100, 1'b1, 5'd1, 1'b1, 1'b0);
        cycle(1'b1, 6'h02, 32'hB, 32'h104, 1'b1, 5'd2, 1'b0, 1'b0);
        cycle(1'b1, 6'h02, 32'hC, 32'h108, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle(1'b1, 6'h02, 32'hC, 32'h108, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle(1'b1, 6'h02, 32'hC, 32'h108, 1'b1, 5'd3, 1'b1, 1'b0);
        cycle(1'b1, 6'h02, 32'hC, 32'h108, 1'b1, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Flush with a beat presented in the flush cycle.
        cycle(1'b1, 6'h03, 32'h1, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0);
        cycle(1'b1, 6'h03, 32'h2, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0);
        cycle(1'b1, 6'h03, 32'hDEAD, 32'h0, 1'b1, 5'd6, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Non-skid combinational ready: stall with M full, then release with a new beat.
        cycle(1'b1, 6'h04, 32'h44, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0);
        cycle(1'b0, 6'h04, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 6'h04, 32'h55, 32'h0, 1'b1, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Bubble masking: invalid gap with ife=1, ri=7 on the inputs.
        cycle(1'b1, 6'h05, 32'h77, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 6'h05, 32'h77, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
        cycle(1'b1, 6'h05, 32'h78, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0);
        idle(1'b1);

        // Asynchronous reset mid-stream with occ=2 in the skid instance.
        cycle(1'b1, 6'h06, 32'h61, 32'h0, 1'b1, 5'd1, 1'b1, 1'b0);
        cycle(1'b1, 6'h06, 32'h62, 32'h0, 1'b1, 5'd2, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("pre_reset_occ", 128'(occ1), 128'(2));
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(ov1), 128'(0));
        check("rst_out_op", 128'(op1), 128'(NOP1));
        check("rst_out_ife", 128'(ife1), 128'(0));
        check("rst_occ", 128'(occ1), 128'(0));
        check("rst_in_ready", 128'(rdy1), 128'(1));
        check("rst_noskid_op", 128'(op0), 128'(NOP0));
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 3) != 0), OP_W'($urandom), $urandom, $urandom,
                  1'($urandom), REG_W'($urandom), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 31) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
